// File: rtl/prbs_pkg.sv
// Shared constants, state encoding and tap helper for the PRBS7 checker.
package prbs_pkg;

  localparam int unsigned PRBS_W      = 7;
  localparam int unsigned TAP_HI      = 6;
  localparam int unsigned TAP_LO      = 5;
  localparam int unsigned LOCK_THRESH = 16;
  localparam int unsigned WIN_LEN     = 64;
  localparam int unsigned ERR_THRESH  = 8;

  localparam int unsigned FILL_W  = $clog2(PRBS_W);
  localparam int unsigned MATCH_W = $clog2(LOCK_THRESH);
  localparam int unsigned WIN_W   = $clog2(WIN_LEN);
  localparam int unsigned WERR_W  = $clog2(ERR_THRESH) + 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic prbs_predict(input logic [PRBS_W-1:0] sr);
    return sr[TAP_HI] ^ sr[TAP_LO];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr wins over a same-cycle increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) serial checker: search/verify/lock FSM with windowed loss-of-lock.
module prbs_checker
  import prbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  state_t              state, state_n;
  logic [PRBS_W-1:0]   sr, sr_n;
  logic [FILL_W-1:0]   fill_cnt, fill_n;
  logic [MATCH_W-1:0]  match_cnt, match_n;
  logic [WIN_W-1:0]    win_cnt, win_n;
  logic [WERR_W-1:0]   win_err, werr_n;
  logic [WERR_W-1:0]   werr_sum;
  logic                pred;
  logic                mismatch;
  logic                bit_chk;
  logic                bit_err;

  assign pred     = prbs_predict(sr);
  assign mismatch = bit_in ^ pred;
  assign bit_chk  = bit_valid && (state == LOCKED);
  assign bit_err  = bit_chk && mismatch;
  assign werr_sum = win_err + WERR_W'(mismatch);

  always_comb begin
    state_n = state;
    sr_n    = sr;
    fill_n  = fill_cnt;
    match_n = match_cnt;
    win_n   = win_cnt;
    werr_n  = win_err;
    if (bit_valid) begin
      unique case (state)
        SEARCH: begin
          sr_n = {sr[PRBS_W-2:0], bit_in};
          if (fill_cnt == FILL_W'(PRBS_W - 1)) begin
            state_n = VERIFY;
            fill_n  = '0;
            match_n = '0;
          end else begin
            fill_n = fill_cnt + FILL_W'(1);
          end
        end
        VERIFY: begin
          sr_n = {sr[PRBS_W-2:0], bit_in};
          if (mismatch) begin
            match_n = '0;
          end else if (sr != '0) begin
            if (match_cnt == MATCH_W'(LOCK_THRESH - 1)) begin
              state_n = LOCKED;
              match_n = '0;
              win_n   = '0;
              werr_n  = '0;
            end else begin
              match_n = match_cnt + MATCH_W'(1);
            end
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a single flipped input costs one error.
          sr_n = {sr[PRBS_W-2:0], pred};
          if (werr_sum == WERR_W'(ERR_THRESH)) begin
            state_n = SEARCH;
            fill_n  = '0;
            match_n = '0;
            win_n   = '0;
            werr_n  = '0;
          end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win_cnt + WIN_W'(1);
            werr_n = werr_sum;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      win_cnt   <= win_n;
      win_err   <= werr_n;
      locked    <= (state == LOCKED);
      err_pulse <= bit_err;
    end
  end

  sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_err),
    .clr   (clr_cnt),
    .count (err_cnt)
  );

  sat_counter #(.WIDTH(32)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_chk),
    .clr   (clr_cnt),
    .count (bit_cnt)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock timing, error accounting, loss of lock, reset.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [6:0]  gen;

  prbs_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        flip;
    logic        clr;
    logic        exp_pulse;
    logic [15:0] exp_err;
    logic [31:0] exp_bits;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    bit_valid = v;
    bit_in    = b;
    clr_cnt   = c;
    @(posedge clk);
    #1;
  endtask

  // One valid bit from the reference PRBS7 generator, optionally inverted.
  task automatic send(input logic flip, input logic c);
    logic nb;
    nb  = gen[6] ^ gen[5];
    gen = {gen[5:0], nb};
    step(1'b1, nb ^ flip, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    gen = 7'h01;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 32'd2};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'd3};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 32'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 32'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 32'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd1};

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0; gen = 7'h01;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("reset_locked",    32'(locked),    32'd0);
    check("reset_err_pulse", 32'(err_pulse), 32'd0);
    check("reset_err_cnt",   32'(err_cnt),   32'd0);
    check("reset_bit_cnt",   bit_cnt,        32'd0);
    rst = 1'b0;

    // Clean stream: locked rises after exactly 24 valid bits.
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      check($sformatf("acq_locked_%0d", i), 32'(locked), (i >= 24) ? 32'd1 : 32'd0);
    end
    check("acq_err_cnt", 32'(err_cnt), 32'd0);
    check("acq_bit_cnt", bit_cnt, 32'd1);

    // Single flipped bit.
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
    check("single_pre_pulse", 32'(err_pulse), 32'd0);
    send(1'b1, 1'b0);
    check("single_pulse",   32'(err_pulse), 32'd1);
    check("single_err_cnt", 32'(err_cnt),   32'd1);
    check("single_locked",  32'(locked),    32'd1);
    send(1'b0, 1'b0);
    check("single_pulse_end", 32'(err_pulse), 32'd0);
    check("single_err_hold",  32'(err_cnt),   32'd1);
    check("single_locked2",   32'(locked),    32'd1);

    // Table: gapped valid, errors and clears while locked.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].valid) send(tbl[i].flip, tbl[i].clr);
      else step(1'b0, tbl[i].flip, tbl[i].clr);
      check($sformatf("tbl_pulse_%0d", i),  32'(err_pulse), 32'(tbl[i].exp_pulse));
      check($sformatf("tbl_err_%0d", i),    32'(err_cnt),   32'(tbl[i].exp_err));
      check($sformatf("tbl_bits_%0d", i),   bit_cnt,        tbl[i].exp_bits);
      check($sformatf("tbl_locked_%0d", i), 32'(locked),    32'd1);
    end

    // Eight errors in one window: lose lock, keep counts, relock.
    do_reset();
    for (int i = 0; i < 24; i++) send(1'b0, 1'b0);
    check("burst_pre_locked", 32'(locked), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      send((k % 2) == 0, 1'b0);
    end
    check("burst_err_cnt",  32'(err_cnt),   32'd8);
    check("burst_pulse",    32'(err_pulse), 32'd1);
    check("burst_locked_e", 32'(locked),    32'd1);
    for (int j = 1; j <= 24; j++) begin
      send(1'b0, 1'b0);
      if (j == 1 || j == 23 || j == 24)
        check($sformatf("relock_%0d", j), 32'(locked), (j == 24) ? 32'd1 : 32'd0);
    end
    check("relock_err_kept", 32'(err_cnt), 32'd8);

    // Seven errors either side of a window wrap must not drop lock.
    for (int i = 1; i <= 7; i++) send(1'b1, 1'b0);
    for (int i = 8; i <= 63; i++) send(1'b0, 1'b0);
    for (int i = 64; i <= 70; i++) send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    check("wrap_locked",  32'(locked),  32'd1);
    check("wrap_err_cnt", 32'(err_cnt), 32'd22);

    // Constant zero input must never lock.
    do_reset();
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        step(1'b1, 1'b0, 1'b0);
        if (locked) seen = 1'b1;
      end
      check("zeros_never_lock", 32'(seen), 32'd0);
    end

    // Reset while locked overrides a same-cycle error and clear.
    do_reset();
    for (int i = 0; i < 24; i++) send(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    check("rst_pre_err_cnt", 32'(err_cnt), 32'd5);
    check("rst_pre_locked",  32'(locked),  32'd1);
    rst = 1'b1;
    send(1'b1, 1'b1);
    rst = 1'b0;
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_bit_cnt",   bit_cnt,        32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    for (int j = 1; j <= 24; j++) begin
      send(1'b0, 1'b0);
      if (j == 1 || j == 23 || j == 24)
        check($sformatf("rst_relock_%0d", j), 32'(locked), (j == 24) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
